// File: rtl/rsa_xcel_mont_montmularb.sv
// Two-requester arbiter in front of one shared Montgomery multiplier; one operation in flight.
// Optional macro RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN: ties always go to requester 0.
module rsa_xcel_mont_montmularb (
    input  logic        clk,
    input  logic        reset,
    input  logic [95:0] req0_msg,
    input  logic        req0_val,
    output logic        req0_rdy,
    output logic [31:0] resp0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    input  logic [95:0] req1_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [31:0] resp1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [95:0] mul_req_msg,
    output logic        mul_req_val,
    input  logic        mul_req_rdy,
    input  logic [31:0] mul_resp_msg,
    input  logic        mul_resp_val,
    output logic        mul_resp_rdy,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StReturn} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [95:0] opnd_q, opnd_d;
    logic [31:0] result_q, result_d;
    logic        winner;
    logic        is_idle;
`ifndef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
    logic        last_q, last_d;
`endif

    always_comb begin
        if (req0_val && req1_val) begin
`ifdef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_q;
`endif
        end else begin
            winner = req1_val;
        end
    end

    assign is_idle = (state_q == StIdle);

    // Every handshake output is forced low while reset is asserted.
    assign req0_rdy     = reset && is_idle && !winner && req0_val;
    assign req1_rdy     = reset && is_idle && winner && req1_val;
    assign mul_req_val  = reset && (state_q == StSend);
    assign mul_resp_rdy = reset && (state_q == StWait);
    assign resp0_val    = reset && (state_q == StReturn) && !owner_q;
    assign resp1_val    = reset && (state_q == StReturn) && owner_q;
    assign mul_req_msg  = opnd_q;
    assign resp0_msg    = result_q;
    assign resp1_msg    = result_q;
    assign owner        = owner_q;
    assign busy         = !is_idle;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        opnd_d   = opnd_q;
        result_d = result_q;
`ifndef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (req0_rdy || req1_rdy) begin
                    opnd_d  = winner ? req1_msg : req0_msg;
                    owner_d = winner;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (mul_req_rdy) state_d = StWait;
            end
            StWait: begin
                if (mul_resp_val) begin
                    result_d = mul_resp_msg;
                    state_d  = StReturn;
                end
            end
            StReturn: begin
                if (owner_q ? resp1_rdy : resp0_rdy) begin
`ifndef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
                    last_d = owner_q;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            opnd_q   <= '0;
            result_q <= '0;
`ifndef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
`ifndef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_rsa_xcel_mont_montmularb.sv
// Bench for rsa_xcel_mont_montmularb: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_rsa_xcel_mont_montmularb;

`ifdef RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] req0_msg, req1_msg, mul_req_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [31:0] resp0_msg, resp1_msg, mul_resp_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
    logic        owner, busy;

    int checks   = 0;
    int failures = 0;
    bit last_m;

    always #5 clk = ~clk;

    rsa_xcel_mont_montmularb dut (
        .clk         (clk),
        .reset       (reset),
        .req0_msg    (req0_msg),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .resp0_msg   (resp0_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .req1_msg    (req1_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .resp1_msg   (resp1_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy),
        .mul_req_msg (mul_req_msg),
        .mul_req_val (mul_req_val),
        .mul_req_rdy (mul_req_rdy),
        .mul_resp_msg(mul_resp_msg),
        .mul_resp_val(mul_resp_val),
        .mul_resp_rdy(mul_resp_rdy),
        .owner       (owner),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] rand_msg();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One full transaction; the winner is predicted from the arbitration rule alone.
    task automatic txn(input bit v0, input bit v1, input logic [95:0] m0,
                       input logic [95:0] m1, input int lat, input int mstall,
                       input int rstall, input bit spur, input logic [31:0] mres);
        int w;
        int n;
        logic [95:0] wm;
        if (v0 && v1) w = FixedPrio ? 0 : (last_m ? 0 : 1);
        else          w = v1 ? 1 : 0;
        wm = (w == 1) ? m1 : m0;
        req0_val = v0; req0_msg = m0; req1_val = v1; req1_msg = m1;
        #1;
        check("req0_rdy_grant", req0_rdy, (w == 0) && v0);
        check("req1_rdy_grant", req1_rdy, (w == 1) && v1);
        check("busy_idle", busy, 1'b0);
        n = 0;
        tick(); n++;
        for (int i = 0; i <= mstall; i++) begin
            mul_req_rdy  = (i == mstall);
            mul_resp_val = spur && (i == 0);
            mul_resp_msg = 32'hDEAD_BEEF;
            #1;
            check("mul_req_val_send", mul_req_val, 1'b1);
            check("mul_req_msg_send", mul_req_msg, wm);
            check("owner_send", owner, w == 1);
            check("mul_resp_rdy_send", mul_resp_rdy, 1'b0);
            check("req_rdy_send", {req0_rdy, req1_rdy}, 2'b00);
            tick(); n++;
        end
        mul_req_rdy = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            mul_resp_val = (i == lat);
            mul_resp_msg = (i == lat) ? mres : $urandom;
            #1;
            check("mul_resp_rdy_wait", mul_resp_rdy, 1'b1);
            check("mul_req_val_wait", mul_req_val, 1'b0);
            check("req_rdy_wait", {req0_rdy, req1_rdy}, 2'b00);
            tick(); n++;
        end
        mul_resp_val = 1'b0;
        mul_resp_msg = $urandom;
        check("latency", n, lat + 2 + mstall);
        for (int i = 0; i <= rstall; i++) begin
            resp0_rdy = (w == 0) && (i == rstall);
            resp1_rdy = (w == 1) && (i == rstall);
            #1;
            check("resp_val_owner", (w == 1) ? resp1_val : resp0_val, 1'b1);
            check("resp_val_other", (w == 1) ? resp0_val : resp1_val, 1'b0);
            check("resp_msg", (w == 1) ? resp1_msg : resp0_msg, mres);
            check("req_rdy_return", {req0_rdy, req1_rdy}, 2'b00);
            tick();
        end
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        last_m = (w == 1);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        logic [95:0] msg;
        bit rv0, rv1;
        reset = 1'b0;
        req0_msg = '0; req1_msg = '0; req0_val = 1'b1; req1_val = 1'b1;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        mul_req_rdy = 1'b1; mul_resp_val = 1'b1; mul_resp_msg = 32'h1234_5678;
        tick(); tick();
        check("rst_req_rdy", {req0_rdy, req1_rdy}, 2'b00);
        check("rst_resp_val", {resp0_val, resp1_val}, 2'b00);
        check("rst_mul_handshake", {mul_req_val, mul_resp_rdy}, 2'b00);
        check("rst_busy_owner", {busy, owner}, 2'b00);
        check("rst_data", {mul_req_msg, resp0_msg}, 128'h0);
        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        mul_req_rdy = 1'b0; mul_resp_val = 1'b0;
        tick();
        last_m = 1'b1;

        // Four back-to-back ties straight out of reset.
        for (int i = 0; i < 4; i++) txn(1, 1, rand_msg(), rand_msg(), 2, 0, 0, 0, $urandom);

        // Single request with a 4-cycle multiplier.
        txn(1, 0, {32'h0000_000D, 32'h5, 32'h7}, '0, 4, 0, 0, 0, 32'h3);

        // Back-pressure on the multiplier and on the response.
        txn(0, 1, rand_msg(), rand_msg(), 3, 5, 3, 0, $urandom);

        // Stray result while still sending.
        txn(1, 0, rand_msg(), rand_msg(), 2, 1, 0, 1, 32'h1);

        for (int i = 0; i < 16; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(rv0, rv1, rand_msg(), rand_msg(), $urandom_range(1, 5),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom);
        end

        // Reset while the multiplier holds an operation.
        msg = rand_msg();
        req0_val = 1'b1; req0_msg = msg; req1_val = 1'b0;
        tick();
        req0_val = 1'b0; mul_req_rdy = 1'b1;
        tick();
        mul_req_rdy = 1'b0; reset = 1'b0;
        #1;
        check("midrst_resp_rdy", mul_resp_rdy, 1'b0);
        tick();
        reset = 1'b1; mul_resp_val = 1'b1; mul_resp_msg = 32'hCAFE_F00D; resp0_rdy = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_resp_val", {resp0_val, resp1_val}, 2'b00);
        check("midrst_idle_resp_rdy", mul_resp_rdy, 1'b0);
        tick();
        check("midrst_still_idle", {busy, resp0_val, resp1_val}, 3'b000);
        mul_resp_val = 1'b0; resp0_rdy = 1'b0;
        last_m = 1'b1;
        txn(0, 1, rand_msg(), rand_msg(), 3, 0, 1, 0, $urandom);
        txn(1, 1, rand_msg(), rand_msg(), 1, 0, 0, 0, $urandom);
        req0_val = 1'b0; req1_val = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_xcel_mont_montmularb.md
RSA_XCEL_MONT_MONTMULARB -- requirements
Module: rsa_xcel_mont_MontMulArb

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset; state SHALL be reset on a posedge clk where reset==0.
REQ-004 req0_msg  input  96  requester 0 operands {n[95:64], a[63:32], b[31:0]}.
REQ-005 req0_val  input  1  requester 0 request valid.
REQ-006 req0_rdy  output  1  requester 0 request accepted.
REQ-007 resp0_msg  output  32  result returned to requester 0.
REQ-008 resp0_val  output  1  requester 0 result valid.
REQ-009 resp0_rdy  input  1  requester 0 can take the result.
REQ-010 req1_msg, req1_val, req1_rdy, resp1_msg, resp1_val, resp1_rdy SHALL match REQ-004..REQ-009 for requester 1.
REQ-011 mul_req_msg  output  96  operands to the shared Montgomery multiplier {n, a, b}.
REQ-012 mul_req_val  output  1  multiplier request valid.
REQ-013 mul_req_rdy  input  1  multiplier accepts the request.
REQ-014 mul_resp_msg  input  32  multiplier result.
REQ-015 mul_resp_val  input  1  multiplier result valid.
REQ-016 mul_resp_rdy  output  1  arbiter accepts the result.
REQ-017 owner  output  1  index of the requester currently holding the multiplier; valid when busy==1.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 A transfer on any stream SHALL occur only on a cycle with val==1 and rdy==1.
REQ-020 FSM states SHALL be IDLE, SEND, WAIT and RETURN; only one multiplication SHALL be outstanding at a time.
REQ-021 IDLE: the winner SHALL be the sole valid requester; if both are valid, the winner SHALL be the requester not granted last (round-robin).
REQ-022 IDLE: only the winner's reqX_rdy SHALL be 1, and it SHALL be 1 only while that requester's reqX_val==1; the loser's rdy SHALL be 0.
REQ-023 IDLE: on a request transfer, reqX_msg SHALL be registered, owner SHALL be set to X and the FSM SHALL enter SEND.
REQ-024 SEND: mul_req_val SHALL be 1 and mul_req_msg SHALL hold the registered operands; on mul_req_rdy==1 the FSM SHALL enter WAIT.
REQ-025 WAIT: mul_resp_rdy SHALL be 1; on mul_resp_val==1 mul_resp_msg SHALL be registered and the FSM SHALL enter RETURN.
REQ-026 mul_resp_rdy SHALL be 0 outside WAIT; mul_resp_val outside WAIT SHALL be ignored.
REQ-027 RETURN: resp[owner]_val SHALL be 1 with the registered result; the other resp_val SHALL be 0; on resp[owner]_rdy==1 the last-grant pointer SHALL be set to owner and the FSM SHALL enter IDLE.
REQ-028 Outside IDLE, both reqX_rdy SHALL be 0; a new request SHALL be accepted no earlier than the cycle after the RETURN transfer.
REQ-029 With zero-stall handshakes and multiplier latency L cycles from request to result, request acceptance to resp_val SHALL take L+2 cycles.
REQ-030 The registered messages SHALL remain stable while their val is 1 and rdy is 0.

Reset
REQ-031 While reset==0 at posedge: FSM SHALL go to IDLE, owner to 0, last-grant pointer to 1 (requester 0 wins the first tie), data registers to 0.
REQ-032 While reset==0, all rdy and val outputs SHALL be driven 0; reset mid-operation SHALL abandon the in-flight operation without returning a result.

Configuration
REQ-033 With macro RSA_XCEL_MONT_MONTMULARB_FIXED_PRIO_EN defined, REQ-021 tie-breaking SHALL instead always grant requester 0 and the last-grant pointer SHALL be unused; without it, round-robin per REQ-021 SHALL apply.

Verification
REQ-034 Single request: req0 {n=0x0000_000D, a=0x5, b=0x7}, multiplier model returns 0x3 after L=4 -> resp0_val with 0x3 exactly 6 cycles after acceptance, resp1_val never set.
REQ-035 Tie after reset: req0 and req1 valid in the same cycle -> req0 granted first, then req1; four back-to-back ties -> grant order 0,1,0,1 (0,0,0,0 with FIXED_PRIO_EN, req1 starved while req0 is held valid).
REQ-036 Back-pressure: mul_req_rdy=0 for 5 cycles, then resp1_rdy=0 for 3 cycles -> mul_req_msg and resp1_msg stable throughout; both req_rdy remain 0.
REQ-037 Spurious result: mul_resp_val=1 with 0xDEAD_BEEF while in SEND -> ignored (mul_resp_rdy=0); the later real result 0x1 is delivered.
REQ-038 Reset mid-op: reset=0 during WAIT -> next cycle busy=0, no resp_val, and the next req1 completes normally.
